// File: rtl/goertzel_axis_packer.sv
// Goertzel result packer: narrows each {re,im} result from OW to SAW bits,
// packs LANES results into one wide AXI4-Stream beat and frames the beats
// into packets of PKT_BEATS with tlast. A flush closes a partial beat/packet.

// Narrowing of one signed component: truncate, or round half-up and saturate.
module goertzel_axis_packer_conv #(
  parameter int OW    = 20,
  parameter int SAW   = 16,
  parameter int ROUND = 0
) (
  input  logic [OW-1:0]  x,
  output logic [SAW-1:0] y
);
  localparam int DROP = OW - SAW;
  localparam logic [OW:0] HALF = (OW+1)'(1) << (DROP - 1);

  logic [OW:0]  sum;
  logic [SAW:0] sh;
  logic         unused_lsbs;

  // One guard bit above the sign absorbs the +half carry, so overflow shows
  // up as a mismatch between the top two bits of the shifted value.
  assign sum         = {x[OW-1], x} + HALF;
  assign sh          = sum[OW:DROP];
  assign unused_lsbs = ^sum[DROP-1:0];

  // Select truncation or rounded value, clamping to the SAW-bit signed range
  always_comb begin
    y = x[OW-1:DROP];
    if (ROUND != 0) begin
      if (sh[SAW] != sh[SAW-1]) y = {sh[SAW], {(SAW-1){~sh[SAW]}}};
      else                      y = sh[SAW-1:0];
    end
  end
endmodule

module goertzel_axis_packer #(
  parameter int OW        = 20,
  parameter int SAW       = 16,
  parameter int LANES     = 4,
  parameter int PKT_BEATS = 8,
  parameter int ROUND     = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic [2*OW-1:0]          s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [LANES*2*SAW-1:0]   m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast
);
  localparam int LW = (LANES > 1)     ? $clog2(LANES)     : 1;
  localparam int BW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_BEATS - 1);

  logic [LANES-1:0][2*SAW-1:0] staging, stg_nxt;
  logic [2*SAW-1:0]            conv;
  logic [LW-1:0]               lane_cnt;
  logic [BW-1:0]               beat_cnt, beat_nxt;
  logic                        flush_pend;
  logic                        s_hs, m_hs, out_free, fill, flush_load, load, load_last, flush_set;

  // re and im go through identical converters; instance 1 takes the upper half
  goertzel_axis_packer_conv #(.OW(OW), .SAW(SAW), .ROUND(ROUND)) u_conv [1:0] (
    .x (s_axis_tdata),
    .y (conv)
  );

  assign s_hs       = s_axis_tvalid && s_axis_tready;
  assign m_hs       = m_axis_tvalid && m_axis_tready;
  assign out_free   = !m_axis_tvalid || m_axis_tready;
  // Only the last lane needs the output register; earlier lanes land in staging.
  assign s_axis_tready = i_rst_n && !flush_pend && ((lane_cnt != LAST_LANE) || out_free);
  assign fill       = s_hs && (lane_cnt == LAST_LANE);
  assign flush_load = flush_pend && out_free;
  assign load       = fill || flush_load;
  // A flush only matters if something is left in staging after this cycle's accept.
  assign flush_set  = i_flush && !fill && (s_hs || (lane_cnt != '0));

  // Staging contents after this cycle's accept, and the beat index of the next load
  always_comb begin
    stg_nxt = staging;
    if (s_hs) stg_nxt[lane_cnt] = conv;
    beat_nxt = beat_cnt;
    if (m_hs) beat_nxt = m_axis_tlast ? '0 : beat_cnt + 1'b1;
    load_last = (beat_nxt == LAST_BEAT) || flush_load || (fill && i_flush);
  end

  // Lane packing, output register with hold under backpressure, and packet framing
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      staging       <= '0;
      lane_cnt      <= '0;
      beat_cnt      <= '0;
      flush_pend    <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      beat_cnt <= beat_nxt;
      if (load) begin
        m_axis_tdata  <= stg_nxt;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= load_last;
        staging       <= '0;
        lane_cnt      <= '0;
      end else begin
        if (m_hs) m_axis_tvalid <= 1'b0;
        staging <= stg_nxt;
        if (s_hs) lane_cnt <= lane_cnt + 1'b1;
      end
      // Loading the partial beat retires the flush; a new request cannot
      // arrive for it since staging is empty afterwards.
      if (flush_load)     flush_pend <= 1'b0;
      else if (flush_set) flush_pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_goertzel_axis_packer.sv
// Directed bench for goertzel_axis_packer: a truncating and a rounding
// instance share all inputs; beats are collected and compared with
// hand-computed lanes or with beats rebuilt from the accepted samples.
module tb_goertzel_axis_packer;
  localparam int OW = 20, SAW = 16, LANES = 4, PKT = 8, MW = LANES*2*SAW;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [2*OW-1:0] s_data = '0;
  logic s_ready0, s_ready1, m_valid0, m_valid1, m_last0, m_last1;
  logic [MW-1:0] m_data0, m_data1;

  always #5 clk = ~clk;

  goertzel_axis_packer #(.OW(OW), .SAW(SAW), .LANES(LANES), .PKT_BEATS(PKT), .ROUND(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready0),
    .m_axis_tdata(m_data0), .m_axis_tvalid(m_valid0), .m_axis_tready(m_ready), .m_axis_tlast(m_last0));

  goertzel_axis_packer #(.OW(OW), .SAW(SAW), .LANES(LANES), .PKT_BEATS(PKT), .ROUND(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready1),
    .m_axis_tdata(m_data1), .m_axis_tvalid(m_valid1), .m_axis_tready(m_ready), .m_axis_tlast(m_last1));

  typedef struct {
    logic [19:0] re;
    logic [19:0] im;
    logic [31:0] e0;   // expected lane, truncating instance
    logic [31:0] e1;   // expected lane, rounding instance
  } vec_t;

  vec_t tbl [8];
  int n_vec = 0, n_bad = 0, last_wait = 0;
  logic [2*OW-1:0] acc [$];
  logic [MW:0] got0 [$], got1 [$];

  task automatic check(input string name, input logic [MW:0] act, input logic [MW:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: settle, log handshakes, advance to just after the next edge
  task automatic cyc(output bit took);
    #1;
    took = s_valid && s_ready0;
    if (took) acc.push_back(s_data);
    if (m_valid0 && m_ready) got0.push_back({m_last0, m_data0});
    if (m_valid1 && m_ready) got1.push_back({m_last1, m_data1});
    @(posedge clk); #1;
  endtask

  task automatic tick();
    bit d;
    cyc(d);
  endtask

  task automatic send(input logic [2*OW-1:0] d);
    bit took = 1'b0;
    int t = 0;
    s_data = d; s_valid = 1'b1;
    while (!took && t < 200) begin cyc(took); t++; end
    last_wait = t;
    if (!took) check("send timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  task automatic drain(input int n, input string name);
    int t = 0;
    while (got0.size() < n && t < 300) begin tick(); t++; end
    check(name, got0.size(), n);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; s_valid = 1'b0; flush = 1'b0; m_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    acc.delete(); got0.delete(); got1.delete();
  endtask

  function automatic logic [2*OW-1:0] gen(input int i);
    logic [19:0] re, im;
    re = 20'(i*'h1357 + 'h10);
    im = 20'('hFFFF0 - i*'h2468);
    return {re, im};
  endfunction

  // Truncating beat built from accepted samples st..st+cnt-1, rest zero
  function automatic logic [MW:0] model(input int st, input int cnt, input bit last);
    logic [MW:0] r = '0;
    for (int k = 0; k < cnt; k++)
      if (st + k < acc.size()) r[k*32 +: 32] = {acc[st+k][39:24], acc[st+k][19:4]};
    r[MW] = last;
    return r;
  endfunction

  function automatic logic [MW:0] beat_at(input bit which, input int b);
    if (which == 1'b0) return (b < got0.size()) ? got0[b] : '0;
    else               return (b < got1.size()) ? got1[b] : '0;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{20'h00010, 20'hFFFF0, 32'h0001FFFF, 32'h0001FFFF};
    tbl[1] = '{20'h7FFF8, 20'h80000, 32'h7FFF8000, 32'h7FFF8000};
    tbl[2] = '{20'h00018, 20'h00017, 32'h00010001, 32'h00020001};
    tbl[3] = '{20'hFFFF8, 20'hFFFF7, 32'hFFFFFFFF, 32'h0000FFFF};
    tbl[4] = '{20'h12345, 20'hABCDE, 32'h1234ABCD, 32'h1234ABCE};
    tbl[5] = '{20'h7FFFF, 20'h00007, 32'h7FFF0000, 32'h7FFF0000};
    tbl[6] = '{20'h80008, 20'h7FFF7, 32'h80007FFF, 32'h80017FFF};
    tbl[7] = '{20'h00008, 20'hFFFF9, 32'h0000FFFF, 32'h00010000};

    // Reset state
    @(posedge clk); #1;
    tick(); tick();
    check("rst tvalid", m_valid0, 0);
    check("rst tdata", m_data0, 0);
    check("rst tlast", m_last0, 0);
    check("rst tready", s_ready0, 0);
    rst_n = 1'b1; acc.delete(); got0.delete(); got1.delete();

    // 1: four identical samples, one-cycle latency after the 4th accept
    m_ready = 1'b1;
    s_data = {20'h00010, 20'hFFFF0}; s_valid = 1'b1;
    tick(); tick(); tick();
    check("t1 no early tvalid", m_valid0, 0);
    tick();
    s_valid = 1'b0;
    check("t1 tvalid", m_valid0, 1);
    check("t1 tdata", m_data0, {4{32'h0001FFFF}});
    check("t1 tlast", m_last0, 0);
    tick();
    check("t1 beats", got0.size(), 1);

    // 4 + table: conversion vectors through both instances
    reset_dut();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) send({tbl[i].re, tbl[i].im});
    tick(); tick(); tick();
    check("tbl beats0", got0.size(), 2);
    check("tbl beats1", got1.size(), 2);
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < LANES; k++) begin
        logic [MW:0] g0, g1;
        g0 = beat_at(1'b0, b); g1 = beat_at(1'b1, b);
        check($sformatf("trunc v%0d", b*4+k), g0[k*32 +: 32], tbl[b*4+k].e0);
        check($sformatf("round v%0d", b*4+k), g1[k*32 +: 32], tbl[b*4+k].e1);
      end

    // 2: 32 back-to-back samples -> 8 beats, tlast on the 8th only
    reset_dut();
    m_ready = 1'b1;
    begin
      bit rdy_ok = 1'b1;
      for (int i = 0; i < 32; i++) begin
        send(gen(i));
        if (last_wait != 1) rdy_ok = 1'b0;
      end
      check("t2 tready steady", rdy_ok, 1);
    end
    drain(8, "t2 beats");
    for (int b = 0; b < 8; b++) check($sformatf("t2 beat%0d", b), beat_at(1'b0, b), model(b*4, 4, b == 7));

    // 3: 10-cycle downstream stall while the stream keeps coming
    reset_dut();
    m_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 24; i++) send(gen(100 + i));
      end
      begin
        logic [MW+1:0] held;
        int lows = 0;
        bit hold_ok = 1'b1;
        repeat (8) @(posedge clk);
        #1 m_ready = 1'b0;
        #1 held = {m_valid0, m_last0, m_data0};
        for (int c = 0; c < 10; c++) begin
          if (c > 0) #1;
          if ({m_valid0, m_last0, m_data0} !== held) hold_ok = 1'b0;
          if (!s_ready0) lows++;
          @(posedge clk); #1;
        end
        m_ready = 1'b1;
        check("t3 held valid", held[MW+1], 1);
        check("t3 hold", hold_ok, 1);
        check("t3 tready drop", lows > 0, 1);
      end
    join
    drain(6, "t3 beats");
    check("t3 accepted", acc.size(), 24);
    for (int b = 0; b < 6; b++) check($sformatf("t3 beat%0d", b), beat_at(1'b0, b), model(b*4, 4, 1'b0));

    // 5: partial flush, then packet restarts at beat 0
    reset_dut();
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(gen(200 + i));
    flush = 1'b1; tick(); flush = 1'b0;
    drain(2, "t5 beats");
    check("t5 full beat", beat_at(1'b0, 0), model(0, 4, 1'b0));
    check("t5 flushed beat", beat_at(1'b0, 1), model(4, 2, 1'b1));
    for (int i = 0; i < 32; i++) send(gen(300 + i));
    drain(10, "t5 restart beats");
    for (int b = 0; b < 8; b++) check($sformatf("t5 pkt beat%0d", b), beat_at(1'b0, 2 + b), model(6 + b*4, 4, b == 7));
    // flush together with the completing sample forces tlast and resets framing
    for (int i = 0; i < 3; i++) send(gen(400 + i));
    flush = 1'b1; send(gen(403)); flush = 1'b0;
    for (int i = 0; i < 4; i++) send(gen(404 + i));
    drain(12, "t5 flush-fill beats");
    check("t5 flush-fill", beat_at(1'b0, 10), model(38, 4, 1'b1));
    check("t5 after flush-fill", beat_at(1'b0, 11), model(42, 4, 1'b0));
    // flush with an empty staging register does nothing
    flush = 1'b1; tick(); flush = 1'b0;
    tick(); tick(); tick();
    check("t5 idle flush beats", got0.size(), 12);
    check("t5 idle flush tready", s_ready0, 1);

    // 6: reset with a pending beat and a partial beat
    reset_dut();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(gen(500 + i));
    check("t6 pending", m_valid0, 1);
    rst_n = 1'b0; tick();
    check("t6 tvalid cleared", m_valid0, 0);
    check("t6 tready in reset", s_ready0, 0);
    rst_n = 1'b1;
    acc.delete(); got0.delete(); got1.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(gen(600 + i));
    tick(); tick();
    check("t6 beats", got0.size(), 1);
    check("t6 clean beat", beat_at(1'b0, 0), model(0, 4, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
